// File: rtl/kmeans_update_unit_if.sv
// Request/data bundle between the k-means update unit and whoever drives it.
interface kmeans_update_unit_if #(
  parameter int unsigned ENGINES = 2,
  parameter int unsigned K       = 16,
  parameter int unsigned SW      = 24,
  parameter int unsigned CW      = 12
);
  logic                      start;
  logic [ENGINES*K*3*SW-1:0] acc_in;
  logic [ENGINES*K*CW-1:0]   cnt_in;
  logic [24*K-1:0]           mean_in;
  logic [K-1:0]              enable_in;
  logic                      busy;
  logic                      done;
  logic [24*K-1:0]           mean_out;
  logic [K-1:0]              enabled_out;
  logic                      converged;

  modport master (
    output start, acc_in, cnt_in, mean_in, enable_in,
    input  busy, done, mean_out, enabled_out, converged
  );

  modport slave (
    input  start, acc_in, cnt_in, mean_in, enable_in,
    output busy, done, mean_out, enabled_out, converged
  );
endinterface

// File: rtl/kmeans_update_unit.sv
// Reduces per-engine cluster accumulators, divides by the cluster count and
// publishes the next mean set with an enabled mask and a convergence flag.
module kmeans_update_unit #(
  parameter int unsigned ENGINES = 2,
  parameter int unsigned K       = 16,
  parameter int unsigned SW      = 24,
  parameter int unsigned CW      = 12,
  parameter int unsigned THRESH  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  kmeans_update_unit_if.slave  bus
);
  localparam int unsigned EXTRA = $clog2(ENGINES);
  localparam int unsigned SSW   = SW + EXTRA;
  localparam int unsigned CCW   = CW + EXTRA;
  localparam int unsigned DW    = SSW + CCW + 8;
  localparam int unsigned EW    = (ENGINES > 1) ? $clog2(ENGINES) : 1;
  localparam int unsigned KW    = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_DIVIDE, S_UPDATE} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [EW-1:0]   eng_q, eng_d;
  logic [2:0]      div_q, div_d;
  logic [SSW-1:0]  sum_q [3];
  logic [SSW-1:0]  sum_d [3];
  logic [CCW-1:0]  cnt_q, cnt_d;
  logic [7:0]      quo_q [3];
  logic [7:0]      quo_d [3];
  logic [24*K-1:0] shmean_q, shmean_d;
  logic [K-1:0]    shen_q, shen_d;
  logic            shconv_q, shconv_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [24*K-1:0] mean_q, mean_d;
  logic [K-1:0]    en_q, en_d;
  logic            conv_q, conv_d;

  logic [31:0]     acc_base, cnt_base, mean_base;
  logic [DW-1:0]   divisor;
  logic [7:0]      old_ch, new_ch, diff;
  logic            live;

  assign acc_base  = 32'(eng_q) * 32'(3*SW*K) + 32'(k_q) * 32'(3*SW);
  assign cnt_base  = 32'(eng_q) * 32'(CW*K) + 32'(k_q) * 32'(CW);
  assign mean_base = 32'(k_q) * 32'd24;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      eng_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      for (int c = 0; c < 3; c++) begin
        sum_q[c] <= '0;
        quo_q[c] <= '0;
      end
      shmean_q <= '0;
      shen_q   <= '0;
      shconv_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mean_q   <= '0;
      en_q     <= '0;
      conv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      eng_q    <= eng_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      quo_q    <= quo_d;
      shmean_q <= shmean_d;
      shen_q   <= shen_d;
      shconv_q <= shconv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mean_q   <= mean_d;
      en_q     <= en_d;
      conv_q   <= conv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    eng_d    = eng_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    quo_d    = quo_q;
    shmean_d = shmean_q;
    shen_d   = shen_q;
    shconv_d = shconv_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mean_d   = mean_q;
    en_d     = en_q;
    conv_d   = conv_q;
    divisor  = '0;
    old_ch   = '0;
    new_ch   = '0;
    diff     = '0;
    live     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_REDUCE;
          k_d      = '0;
          eng_d    = '0;
          cnt_d    = '0;
          sum_d    = '{default: '0};
          shconv_d = 1'b1;
          busy_d   = 1'b1;
        end
      end

      S_REDUCE: begin
        for (int c = 0; c < 3; c++)
          sum_d[c] = sum_q[c] + SSW'(bus.acc_in[acc_base + 32'((2 - c) * SW) +: SW]);
        cnt_d = cnt_q + CCW'(bus.cnt_in[cnt_base +: CW]);
        if (eng_q == EW'(ENGINES - 1)) begin
          state_d = S_DIVIDE;
          div_d   = '0;
        end else begin
          eng_d = eng_q + 1'b1;
        end
      end

      // Restoring division: the channel sum registers double as remainders.
      S_DIVIDE: begin
        divisor = DW'(cnt_q) << (3'd7 - div_q);
        for (int c = 0; c < 3; c++) begin
          if (DW'(sum_q[c]) >= divisor) begin
            sum_d[c] = SSW'(DW'(sum_q[c]) - divisor);
            quo_d[c] = {quo_q[c][6:0], 1'b1};
          end else begin
            quo_d[c] = {quo_q[c][6:0], 1'b0};
          end
        end
        if (div_q == 3'd7) state_d = S_UPDATE;
        else               div_d   = div_q + 3'd1;
      end

      S_UPDATE: begin
        live = bus.enable_in[k_q] && (cnt_q != '0);
        if (live) begin
          shen_d[k_q] = 1'b1;
          for (int c = 0; c < 3; c++) begin
            new_ch = quo_q[c];
            old_ch = bus.mean_in[mean_base + 32'((2 - c) * 8) +: 8];
            diff   = (new_ch > old_ch) ? (new_ch - old_ch) : (old_ch - new_ch);
            if (32'(diff) > THRESH) shconv_d = 1'b0;
            shmean_d[mean_base + 32'((2 - c) * 8) +: 8] = new_ch;
          end
        end else begin
          shen_d[k_q] = 1'b0;
          shmean_d[mean_base +: 24] = bus.mean_in[mean_base +: 24];
        end
        if (k_q == KW'(K - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          mean_d  = shmean_d;
          en_d    = shen_d;
          conv_d  = shconv_d;
        end else begin
          state_d = S_REDUCE;
          k_d     = k_q + 1'b1;
          eng_d   = '0;
          cnt_d   = '0;
          sum_d   = '{default: '0};
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mean_out    = mean_q;
  assign bus.enabled_out = en_q;
  assign bus.converged   = conv_q;
endmodule

// File: tb/tb_kmeans_update_unit.sv
// Bench for kmeans_update_unit: randomized passes on a default-size instance
// against an arithmetic model, plus directed K=2 cases with literal results.
module tb_kmeans_update_unit;
  localparam int unsigned E  = 2;
  localparam int unsigned KB = 16;
  localparam int unsigned KS = 2;
  localparam int unsigned SW = 24;
  localparam int unsigned CW = 12;
  localparam int          LB = KB * (E + 9);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kmeans_update_unit_if #(.ENGINES(E), .K(KB), .SW(SW), .CW(CW)) bif ();
  kmeans_update_unit_if #(.ENGINES(E), .K(KS), .SW(SW), .CW(CW)) s0if ();
  kmeans_update_unit_if #(.ENGINES(E), .K(KS), .SW(SW), .CW(CW)) s4if ();

  kmeans_update_unit #(.ENGINES(E), .K(KB), .SW(SW), .CW(CW), .THRESH(0)) dut_big (
    .clk(clk), .reset(reset), .bus(bif));
  kmeans_update_unit #(.ENGINES(E), .K(KS), .SW(SW), .CW(CW), .THRESH(0)) dut_s0 (
    .clk(clk), .reset(reset), .bus(s0if));
  kmeans_update_unit #(.ENGINES(E), .K(KS), .SW(SW), .CW(CW), .THRESH(4)) dut_s4 (
    .clk(clk), .reset(reset), .bus(s4if));

  // Stimulus kept as plain integers; channel index 0=R, 1=G, 2=B.
  int b_acc  [E][KB][3];
  int b_cnt  [E][KB];
  int b_mean [KB][3];
  bit b_en   [KB];
  int s_acc  [E][KS][3];
  int s_cnt  [E][KS];
  int s_mean [KS][3];
  bit s_en   [KS];

  typedef struct {
    int                fin;
    logic [24*KB-1:0]  m;
    logic [KB-1:0]     en;
    logic              conv;
  } pass_t;

  pass_t            pq[$];
  int               S = -1;
  logic [24*KB-1:0] cur_mean = '0;
  logic [KB-1:0]    cur_en   = '0;
  logic             cur_conv = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Expected result of a pass over the current big-instance stimulus.
  function automatic pass_t model_big(int fin);
    pass_t p;
    int tot, s, q, d;
    p.fin = fin;
    p.conv = 1'b1;
    p.m = '0;
    p.en = '0;
    for (int k = 0; k < KB; k++) begin
      tot = 0;
      for (int e = 0; e < E; e++) tot += b_cnt[e][k];
      p.en[k] = b_en[k] && (tot != 0);
      for (int c = 0; c < 3; c++) begin
        if (p.en[k]) begin
          s = 0;
          for (int e = 0; e < E; e++) s += b_acc[e][k][c];
          q = s / tot;
          d = (q > b_mean[k][c]) ? q - b_mean[k][c] : b_mean[k][c] - q;
          if (d > 0) p.conv = 1'b0;
        end else begin
          q = b_mean[k][c];
        end
        p.m[k*24 + (2-c)*8 +: 8] = 8'(q);
      end
    end
    return p;
  endfunction

  task automatic drive_big();
    for (int k = 0; k < KB; k++) begin
      for (int e = 0; e < E; e++) begin
        for (int c = 0; c < 3; c++)
          bif.acc_in[e*3*SW*KB + k*3*SW + (2-c)*SW +: SW] = 24'(b_acc[e][k][c]);
        bif.cnt_in[e*CW*KB + k*CW +: CW] = 12'(b_cnt[e][k]);
      end
      for (int c = 0; c < 3; c++) bif.mean_in[k*24 + (2-c)*8 +: 8] = 8'(b_mean[k][c]);
      bif.enable_in[k] = b_en[k];
    end
  endtask

  // mode 0: random data; 1: new means equal mean_in; 2: no cluster enabled.
  task automatic gen_big(int mode);
    int tot, total;
    for (int k = 0; k < KB; k++) begin
      b_en[k] = (mode != 2) && ($urandom_range(0, 7) != 0);
      tot = 0;
      for (int e = 0; e < E; e++) begin
        b_cnt[e][k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                                  : int'($urandom_range(0, 9));
        if (mode == 0 && k % 5 == 0) b_cnt[e][k] = 0;
        tot += b_cnt[e][k];
      end
      for (int c = 0; c < 3; c++) begin
        b_mean[k][c] = int'($urandom_range(0, 255));
        if (tot == 0)       total = int'($urandom_range(0, 100000));
        else if (mode == 1) total = b_mean[k][c] * tot + int'($urandom_range(0, tot - 1));
        else                total = int'($urandom_range(0, 256 * tot - 1));
        b_acc[0][k][c] = int'($urandom_range(0, total));
        b_acc[1][k][c] = total - b_acc[0][k][c];
      end
    end
    drive_big();
  endtask

  // Holds start for n edges beginning at first_edge; the model accepts it only when idle.
  task automatic drive_start(int first_edge, int n_edges);
    int g = 0;
    do begin @(posedge clk); #1; g++; end while (cyc + 1 < first_edge && g < 5000);
    for (int i = 0; i < n_edges; i++) begin
      bif.start = 1'b1;
      if (S < 0 || cyc + 1 > S + LB) begin
        S = cyc + 1;
        pq.push_back(model_big(S + LB));
      end
      @(posedge clk); #1;
    end
    bif.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (S >= 0 && cyc <= S + LB && n < 1000) begin @(negedge clk); n++; end
    if (S >= 0 && cyc <= S + LB) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: pass not over after %0d cycles", n);
    end
  endtask

  task automatic reset_at(int target);
    int g = 0;
    do begin @(posedge clk); #1; g++; end while (cyc + 1 < target && g < 5000);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    S = -1;
    pq.delete();
    cur_mean = '0;
    cur_en = '0;
    cur_conv = 1'b0;
    check("busy_after_reset", 64'(bif.busy), 64'd0);
    check("mean_zero_after_reset", 64'(bif.mean_out == '0), 64'd1);
  endtask

  // Compares every cycle against the model's busy window, done pulse and held outputs.
  always @(negedge clk) begin
    if (cmp_on) begin
      bit fin_now;
      fin_now = 1'b0;
      if (pq.size() > 0 && cyc == pq[0].fin) begin
        cur_mean = pq[0].m;
        cur_en   = pq[0].en;
        cur_conv = pq[0].conv;
        void'(pq.pop_front());
        fin_now = 1'b1;
      end
      check("busy", 64'(bif.busy), 64'(S >= 0 && cyc >= S && cyc < S + LB));
      check("done", 64'(bif.done), 64'(fin_now));
      for (int k = 0; k < KB; k++)
        check($sformatf("mean_out[%0d]", k), 64'(bif.mean_out[k*24 +: 24]), 64'(cur_mean[k*24 +: 24]));
      check("enabled_out", 64'(bif.enabled_out), 64'(cur_en));
      check("converged", 64'(bif.converged), 64'(cur_conv));
    end
  end

  task automatic clear_small();
    for (int k = 0; k < KS; k++) begin
      s_en[k] = 1'b1;
      for (int c = 0; c < 3; c++) s_mean[k][c] = 0;
      for (int e = 0; e < E; e++) begin
        s_cnt[e][k] = 0;
        for (int c = 0; c < 3; c++) s_acc[e][k][c] = 0;
      end
    end
  endtask

  task automatic drive_small();
    logic [E*KS*3*SW-1:0] a;
    logic [E*KS*CW-1:0]   n;
    logic [24*KS-1:0]     m;
    logic [KS-1:0]        en;
    for (int k = 0; k < KS; k++) begin
      for (int e = 0; e < E; e++) begin
        for (int c = 0; c < 3; c++) a[e*3*SW*KS + k*3*SW + (2-c)*SW +: SW] = 24'(s_acc[e][k][c]);
        n[e*CW*KS + k*CW +: CW] = 12'(s_cnt[e][k]);
      end
      for (int c = 0; c < 3; c++) m[k*24 + (2-c)*8 +: 8] = 8'(s_mean[k][c]);
      en[k] = s_en[k];
    end
    s0if.acc_in = a;  s0if.cnt_in = n;  s0if.mean_in = m;  s0if.enable_in = en;
    s4if.acc_in = a;  s4if.cnt_in = n;  s4if.mean_in = m;  s4if.enable_in = en;
  endtask

  // Returns the number of edges from the start edge to the done pulse.
  task automatic run_small(output int lat);
    int st, n;
    drive_small();
    @(posedge clk); #1;
    s0if.start = 1'b1;
    s4if.start = 1'b1;
    st = cyc + 1;
    @(posedge clk); #1;
    s0if.start = 1'b0;
    s4if.start = 1'b0;
    n = 0;
    lat = -1;
    while (n < 200 && lat < 0) begin
      @(negedge clk);
      if (s0if.done) lat = cyc - st;
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, s1;
    bif.start = 1'b0;
    s0if.start = 1'b0;
    s4if.start = 1'b0;
    gen_big(0);
    clear_small();
    drive_small();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cmp_on = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(bif.busy), 64'd0);
    check("reset_enabled", 64'(bif.enabled_out), 64'd0);
    check("reset_converged", 64'(bif.converged), 64'd0);

    gen_big(0);
    drive_start(0, 1);
    wait_idle();

    gen_big(1);
    drive_start(0, 1);
    wait_idle();
    check("exact_means_converged", 64'(bif.converged), 64'd1);

    gen_big(2);
    drive_start(0, 1);
    wait_idle();
    check("no_live_converged", 64'(bif.converged), 64'd1);
    check("no_live_enabled", 64'(bif.enabled_out), 64'd0);

    // Starts while busy and on the done edge are ignored; the next edge restarts.
    gen_big(0);
    drive_start(0, 1);
    s1 = S;
    drive_start(s1 + 30, 2);
    drive_start(s1 + LB, 2);
    check("restart_edge", 64'(S), 64'(s1 + LB + 1));
    wait_idle();

    gen_big(0);
    drive_start(0, 1);
    reset_at(S + 50);
    repeat (5) @(negedge clk);
    gen_big(0);
    drive_start(0, 1);
    wait_idle();

    // K=2: reduction, floor division, threshold and keep-old behaviour.
    clear_small();
    s_acc[0][0] = '{300, 200, 100};  s_cnt[0][0] = 3;
    s_acc[1][0] = '{210, 100, 50};   s_cnt[1][0] = 2;
    s_mean[0]   = '{8'h6A, 8'h3C, 8'h1E};
    s_acc[0][1] = '{77, 77, 77};
    s_mean[1]   = '{8'h80, 8'h80, 8'h80};
    run_small(lat);
    check("small_done_edge", 64'(lat), 64'd22);
    check("small_done_s4", 64'(s4if.done), 64'd1);
    check("small_mean0", 64'(s0if.mean_out[23:0]), 64'h663C1E);
    check("small_mean1_kept", 64'(s0if.mean_out[47:24]), 64'h808080);
    check("small_enabled", 64'(s0if.enabled_out), 64'b01);
    check("small_conv_t0", 64'(s0if.converged), 64'd0);
    check("small_conv_t4", 64'(s4if.converged), 64'd1);
    check("small_mean0_t4", 64'(s4if.mean_out[23:0]), 64'h663C1E);
    @(negedge clk);
    check("small_done_drops", 64'(s0if.done), 64'd0);
    check("small_busy_low", 64'(s0if.busy), 64'd0);

    clear_small();
    s_acc[0][0] = '{1000, 350, 0};  s_cnt[0][0] = 4;
    s_acc[1][0] = '{791, 350, 6};   s_cnt[1][0] = 3;
    s_mean[0]   = '{255, 100, 0};
    s_acc[0][1] = '{4, 4, 4};       s_cnt[0][1] = 1;
    s_acc[1][1] = '{6, 6, 6};       s_cnt[1][1] = 2;
    s_mean[1]   = '{3, 3, 3};
    run_small(lat);
    check("floor_done_edge", 64'(lat), 64'd22);
    check("floor_mean", 64'(s0if.mean_out), 64'h030303FF6400);
    check("floor_enabled", 64'(s0if.enabled_out), 64'b11);
    check("floor_conv", 64'(s0if.converged), 64'd1);

    s_en[0] = 1'b0;
    s_acc[0][0] = '{1000, 1000, 1000};  s_cnt[0][0] = 5;
    s_acc[1][0] = '{1000, 1000, 1000};  s_cnt[1][0] = 5;
    s_mean[0]   = '{0, 0, 0};
    run_small(lat);
    check("disabled_mean_kept", 64'(s0if.mean_out), 64'h030303000000);
    check("disabled_enabled", 64'(s0if.enabled_out), 64'b10);
    check("disabled_conv", 64'(s0if.converged), 64'd1);

    for (int i = 0; i < 3; i++) begin
      gen_big(i == 1 ? 1 : 0);
      drive_start(0, 1);
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/kmeans_update_unit.md
# kmeans_update_unit

Parametrised successor of the per-cluster sum unit. After an image pass it reduces the partial accumulators and pixel counters of `ENGINES` clustering engines for all `K` clusters, divides each channel sum by the cluster count, and produces the next mean set in the packed `meanIn` format together with an enabled mask and a convergence flag. It sits between the clustering engines and the mean registers that feed the next iteration.

## Interface
- `ENGINES`, 2: number of engines whose accumulators are reduced (≥1)
- `K`, 16: number of clusters
- `SW`, 24: per-channel sum width per engine
- `CW`, 12: per-cluster count width per engine
- `THRESH`, 0: max per-channel |new−old| (8-bit units) still counted as converged
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-low; sampled on rising `clk`
- `start` in 1: one-cycle request; accepted only in IDLE
- `acc_in` in ENGINES·K·3·SW: engine e, cluster k at `[e*3*SW*K + k*3*SW +: 3*SW]`; within the slice red `[3SW-1:2SW]`, green `[2SW-1:SW]`, blue `[SW-1:0]`
- `cnt_in` in ENGINES·K·CW: engine e, cluster k at `[e*CW*K + k*CW +: CW]`
- `mean_in` in 24·K: current means; cluster k at `[24k +: 24]`, R `[23:16]`, G `[15:8]`, B `[7:0]`
- `enable_in` in K: clusters to process
- `busy` out 1: high while a pass runs
- `done` out 1: one-cycle pulse at pass completion
- `mean_out` out 24·K: new means, same packing as `mean_in`
- `enabled_out` out K: bit k = 1 iff cluster k enabled and reduced count ≠ 0
- `converged` out 1: all live clusters within `THRESH` on every channel

## Operation
- FSM: IDLE → REDUCE → DIVIDE → UPDATE → (next cluster: REDUCE | last: IDLE).
- IDLE: `start`=1 → cluster index k=0, clear reduce registers, enter REDUCE. `start` outside IDLE is ignored.
- REDUCE: ENGINES cycles; cycle e adds engine e's three sums and count into registers of width SW+clog2(ENGINES) (sums) and CW+clog2(ENGINES) (count). No overflow possible.
- DIVIDE: 8 cycles; three parallel restoring dividers, one quotient bit per cycle MSB-first, floor result. Quotient fits 8 bits since each pixel channel ≤255. Runs even for zero count; result is then discarded.
- UPDATE: 1 cycle. Cluster live = `enable_in[k]` & count≠0. Live: shadow mean[k] = quotients, shadow enabled[k]=1, compare each channel against `mean_in[k]`; any |Δ| > THRESH clears the shadow converged flag. Not live: shadow mean[k] = `mean_in[k]`, enabled[k]=0, no effect on convergence.
- Shadow converged is set to 1 on start. Zero live clusters → `converged`=1.
- `acc_in`, `cnt_in`, `mean_in`, `enable_in` must be held stable while `busy`; nothing is captured at start.
- Outputs `mean_out`, `enabled_out`, `converged` are loaded from shadow only at pass completion and held until the next completion.

## Timing
- Reset (`reset`=0 at rising edge): state IDLE, `busy`=0, `done`=0, `mean_out`=0, `enabled_out`=0, `converged`=0, shadow cleared. Reset mid-pass aborts it with no `done` and no output update.
- Start sampled at edge 0 → `busy`=1 after edge 0.
- Per cluster: ENGINES + 8 + 1 cycles; no gaps between clusters.
- Last UPDATE edge = edge K·(ENGINES+9): outputs load, `done`=1, `busy`=0 after it; `done` drops after next edge. Defaults: 16·11 = 176 cycles.
- `start` at the same edge as `done` is ignored (FSM not yet in IDLE); earliest restart is the following edge.
- Latency is independent of data, counts and `enable_in`.

## Test plan
- K=2, ENGINES=2: cluster 0 engine0 R/G/B=300/200/100 cnt 3, engine1 210/100/50 cnt 2, `mean_in[0]`=0x6A3C1E → `mean_out[0]`=0x663C1E (102,60,30), `enabled_out[0]`=1; cluster 1 counts 0, `mean_in[1]`=0x808080 → kept, `enabled_out[1]`=0; `done` exactly at edge 22; `converged`=0 with THRESH=0, =1 with THRESH=4.
- Floor rounding: sum 255·7+6 over cnt 7 → 255; sum 10 over cnt 3 → 3.
- `enable_in[k]`=0 with nonzero count → `mean_out[k]`=`mean_in[k]`, `enabled_out[k]`=0, large Δ does not clear `converged`.
- Defaults (K=16, ENGINES=2), new means equal `mean_in` → `converged`=1, `done` at edge 176, `busy` high for edges 1–176 only.
- `start` pulsed while `busy` and on the `done` cycle → ignored, single `done`; restart on the next edge runs a full second pass.
- `reset`=0 at cycle 50 of a pass → `busy`=0, outputs zero, no `done`; a subsequent start produces correct results.
